serial_paralelo_align: RTL

Parametrised successor of the phy_rx serial-to-parallel stage. Takes LANE_W-bit lanes at the fast clock and finds word alignment by sliding comma search. It declares lock after LOCK_COUNT aligned commas and emits WORD_W-bit words with a valid bit toward the demux stage. Adds realignment, an explicit lock FSM, a word strobe and a resync control.

---
 rtl/serial_paralelo_align.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/serial_paralelo_align.sv
// Lane-to-word deserialiser with sliding comma search, lock FSM and resync.
// Optional loss-of-sync watchdog: define SERPAR_WATCHDOG_EN.
module serial_paralelo_align #(
    parameter int                LANE_W     = 2,
    parameter int                WORD_W     = 8,
    parameter logic [WORD_W-1:0] COMMA      = WORD_W'(8'hBC),
    parameter int                LOCK_COUNT = 4,
    parameter int                WDOG_WORDS = 16
) (
    input  logic              clk16,
    input  logic              reset16,
    input  logic [LANE_W-1:0] serial,
    input  logic              resync,
    output logic [WORD_W:0]   out_paralelo,
    output logic              word_stb,
    output logic              locked,
    output logic              los
);

    localparam int BEATS = WORD_W / LANE_W;
    localparam int BW    = $clog2(BEATS);
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
    localparam logic [7:0]    LOCK_N = 8'(LOCK_COUNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t state, state_n;

    // Only the low bits of the shift register are ever looked at again.
    logic [WORD_W-LANE_W-1:0] sr;
    logic [WORD_W-1:0]        window;
    logic [BW-1:0]            beat, beat_n;
    logic [7:0]               cnt, cnt_n;
    logic                     boundary;
    logic                     is_comma;
    logic                     emit;

    assign window   = {sr, serial};
    assign boundary = (beat == LAST);
    assign is_comma = (window == COMMA);

`ifdef SERPAR_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_WORDS + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(WDOG_WORDS - 1);

    logic [WW-1:0] wd, wd_n;
    logic          los_n;
`endif

    always_comb begin
        state_n = state;
        beat_n  = boundary ? '0 : beat + 1'b1;
        cnt_n   = cnt;
        emit    = 1'b0;
`ifdef SERPAR_WATCHDOG_EN
        wd_n    = wd;
        los_n   = 1'b0;
`endif
        case (state)
            HUNT: begin
                if (is_comma) begin
                    beat_n  = '0;
                    cnt_n   = 8'd1;
                    state_n = (LOCK_COUNT == 1) ? LOCKED : SYNC;
                end
            end
            SYNC: begin
                if (boundary) begin
                    if (is_comma) begin
                        cnt_n = cnt + 8'd1;
                        if (cnt + 8'd1 == LOCK_N)
                            state_n = LOCKED;
                    end else begin
                        cnt_n   = '0;
                        state_n = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    emit = 1'b1;
`ifdef SERPAR_WATCHDOG_EN
                    if (is_comma) begin
                        wd_n = '0;
                    end else if (wd == WD_LAST) begin
                        los_n   = 1'b1;
                        state_n = HUNT;
                        wd_n    = '0;
                    end else begin
                        wd_n = wd + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_n = HUNT;
                cnt_n   = '0;
            end
        endcase

        // resync beats any boundary or comma seen in the same cycle
        if (resync) begin
            state_n = HUNT;
            cnt_n   = '0;
            emit    = 1'b0;
        end
`ifdef SERPAR_WATCHDOG_EN
        if (resync)
            los_n = 1'b0;
        if (state_n != LOCKED)
            wd_n = '0;
`endif
    end

    always_ff @(posedge clk16 or posedge reset16) begin
        if (reset16) begin
            sr           <= '1;
            beat         <= '0;
            cnt          <= '0;
            state        <= HUNT;
            out_paralelo <= '0;
            word_stb     <= 1'b0;
            locked       <= 1'b0;
        end else begin
            sr       <= window[WORD_W-LANE_W-1:0];
            beat     <= beat_n;
            cnt      <= cnt_n;
            state    <= state_n;
            word_stb <= emit;
            locked   <= (state_n == LOCKED);
            if (resync)
                out_paralelo[WORD_W] <= 1'b0;
            else if (emit)
                out_paralelo <= {~is_comma, window};
        end
    end

`ifdef SERPAR_WATCHDOG_EN
    always_ff @(posedge clk16 or posedge reset16) begin
        if (reset16) begin
            wd  <= '0;
            los <= 1'b0;
        end else begin
            wd  <= wd_n;
            los <= los_n;
        end
    end
`else
    assign los = 1'b0;
`endif

endmodule
